alu_accum_seq: RTL and testbench

//  Parametrised accumulator ALU. The A operand comes from switches. The B operand is fed back from the
//  low half of the registered result.

---
 rtl/alu_defs.sv | 20 ++
 rtl/alu_ripple_add.sv | 55 +++++
 rtl/alu_shift_add_mul.sv | 58 +++++
 rtl/alu_accum_seq.sv | 118 +++++++++++
 tb/tb_alu_accum_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_defs.sv
// Shared encodings for the accumulator ALU: operation selects and FSM states.
package alu_defs;

    typedef enum logic [2:0] {
        FUN_INC    = 3'b000,
        FUN_ADD_RC = 3'b001,
        FUN_ADD    = 3'b010,
        FUN_LOGIC  = 3'b011,
        FUN_OR_RED = 3'b100,
        FUN_SHL    = 3'b101,
        FUN_SHR    = 3'b110,
        FUN_MUL    = 3'b111
    } fun_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_ripple_add.sv
// 4-bit ripple-carry adder and a WIDTH-generic chain of them.
// The chain pads operands up to a multiple of 4 bits; because the pad bits
// are zero, bit WIDTH of the padded sum is exactly the carry out of bit WIDTH-1.
module alu_ripple_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[4];
endmodule

module alu_ripple_add #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum_c
);
    localparam int NB = (WIDTH + 3) / 4;
    localparam int NW = 4 * NB;

    logic [NW-1:0] w_a_pad;
    logic [NW-1:0] w_b_pad;
    logic [NW-1:0] w_sum_pad;
    logic [NB:0]   w_c;
    logic [NW:0]   w_full;

    assign w_a_pad = NW'(a);
    assign w_b_pad = NW'(b);
    assign w_c[0]  = 1'b0;

    for (genvar n = 0; n < NB; n++) begin : g_nib
        alu_ripple_add4 u_add4 (
            .a    (w_a_pad[4*n +: 4]),
            .b    (w_b_pad[4*n +: 4]),
            .cin  (w_c[n]),
            .sum  (w_sum_pad[4*n +: 4]),
            .cout (w_c[n+1])
        );
    end

    assign w_full = {w_c[NB], w_sum_pad};
    assign sum_c  = w_full[WIDTH:0];
endmodule

// File: rtl/alu_shift_add_mul.sv
// Multi-cycle shift-add multiplier. start latches the operands; one iteration
// per clock after that. done is asserted combinationally during the final
// iteration, with product carrying the completed value, so the owner can
// capture it on the same edge that performs the last add.
module alu_shift_add_mul
    import alu_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_partial;
    logic [CW-1:0]      r_count;
    logic               r_run;

    logic [2*WIDTH-1:0] w_addend;
    logic [2*WIDTH-1:0] w_next;

    assign w_addend = r_mplier[0] ? (r_mcand << r_count) : '0;
    assign w_next   = r_partial + w_addend;
    assign done     = r_run && (r_count == LAST);
    assign product  = w_next;

    // Latch operands on start, then add/shift/count once per clock until the last iteration.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_count   <= '0;
            r_run     <= 1'b0;
        end else if (start) begin
            r_mcand   <= {{WIDTH{1'b0}}, a};
            r_mplier  <= b;
            r_partial <= '0;
            r_count   <= '0;
            r_run     <= 1'b1;
        end else if (r_run) begin
            r_partial <= w_next;
            r_mplier  <= r_mplier >> 1;
            r_count   <= r_count + 1'b1;
            if (r_count == LAST) begin
                r_run <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_accum_seq.sv
// Accumulator ALU: A from switches, B fed back from the low half of result.
// Handshake: start is a request that is accepted on a rising edge only while
// busy==0; done is a one-cycle pulse meaning result was written on the edge
// just before; busy covers the whole multiply and never overlaps done.
module alu_accum_seq
    import alu_defs::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   a,
    input  logic [2:0]         fun,
    input  logic               start,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               done,
    output state_e             dbg_state
);
    localparam logic [WIDTH:0] SHL_LIM = (WIDTH+1)'(2 * WIDTH);
    localparam logic [WIDTH:0] SHR_LIM = (WIDTH+1)'(WIDTH);

    state_e             r_state;
    logic [2*WIDTH-1:0] r_result;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_rc_b;
    logic [WIDTH:0]     w_rc_sum;
    logic [WIDTH:0]     w_add;
    logic [2*WIDTH-1:0] w_b_ext;
    logic [2*WIDTH-1:0] w_shl;
    logic [WIDTH-1:0]   w_shr;
    logic [2*WIDTH-1:0] w_alu;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_product;

    assign w_b     = r_result[WIDTH-1:0];
    assign w_rc_b  = (fun == FUN_INC) ? WIDTH'(1) : w_b;
    assign w_add   = {1'b0, a} + {1'b0, w_b};
    assign w_b_ext = {{WIDTH{1'b0}}, w_b};
    assign w_shl   = ({1'b0, a} >= SHL_LIM) ? '0 : (w_b_ext << a);
    assign w_shr   = ({1'b0, a} >= SHR_LIM) ? '0 : (w_b >> a);

    alu_ripple_add #(.WIDTH(WIDTH)) u_rc_add (
        .a     (a),
        .b     (w_rc_b),
        .sum_c (w_rc_sum)
    );

    assign w_mul_start = (r_state == ST_IDLE) && start && (fun == FUN_MUL);

    alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (w_mul_start),
        .a       (a),
        .b       (w_b),
        .done    (w_mul_done),
        .product (w_mul_product)
    );

    // Single-cycle operation mux, every op zero-extended to 2*WIDTH.
    always_comb begin
        w_alu = '0;
        case (fun)
            FUN_INC,
            FUN_ADD_RC: w_alu = {{(WIDTH-1){1'b0}}, w_rc_sum};
            FUN_ADD:    w_alu = {{(WIDTH-1){1'b0}}, w_add};
            FUN_LOGIC:  w_alu = {a | w_b, a ^ w_b};
            FUN_OR_RED: w_alu = {{(2*WIDTH-1){1'b0}}, |{a, w_b}};
            FUN_SHL:    w_alu = w_shl;
            FUN_SHR:    w_alu = {{WIDTH{1'b0}}, w_shr};
            default:    w_alu = '0;
        endcase
    end

    // IDLE/MUL sequencer owning the result register and the busy/done flags.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (fun == FUN_MUL) begin
                            r_state <= ST_MUL;
                            r_busy  <= 1'b1;
                        end else begin
                            r_result <= w_alu;
                            r_done   <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_result <= w_mul_product;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign busy      = r_busy;
    assign done      = r_done;
    assign dbg_state = r_state;
endmodule

// File: tb/tb_alu_accum_seq.sv
// Bench for alu_accum_seq: a WIDTH=4 and a WIDTH=8 instance on a shared clock,
// directed steps plus random operations checked against an arithmetic model.
module tb_alu_accum_seq;
    import alu_defs::*;

    // Clock and per-instance reset/stimulus
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst4_n, start4;
    logic [3:0] a4;
    logic [2:0] fun4;
    logic [7:0] result4;
    logic       busy4, done4;
    state_e     st4;

    logic       rst8_n, start8;
    logic [7:0] a8;
    logic [2:0] fun8;
    logic [15:0] result8;
    logic       busy8, done8;
    state_e     st8;

    alu_accum_seq #(.WIDTH(4)) dut4 (
        .clock(clock), .reset_n(rst4_n), .a(a4), .fun(fun4), .start(start4),
        .result(result4), .busy(busy4), .done(done4), .dbg_state(st4)
    );

    alu_accum_seq #(.WIDTH(8)) dut8 (
        .clock(clock), .reset_n(rst8_n), .a(a8), .fun(fun8), .start(start8),
        .result(result8), .busy(busy8), .done(done8), .dbg_state(st8)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;
    logic [7:0]  m_res4;
    logic [15:0] m_res8;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reference: the operation table as plain integer arithmetic, width w.
    function automatic logic [31:0] ref_op(input int f, input longint a, input longint b, input int w);
        longint lim;
        longint r;
        lim = longint'(1) << (2 * w);
        r = 0;
        case (f)
            0:       r = a + 1;
            1, 2:    r = a + b;
            3:       r = (a | b) * (longint'(1) << w) + (a ^ b);
            4:       r = (a != 0 || b != 0) ? 1 : 0;
            5:       r = (a >= 2 * w) ? 0 : (b * (longint'(1) << a)) % lim;
            6:       r = (a >= w) ? 0 : b / (longint'(1) << a);
            7:       r = a * b;
            default: r = 0;
        endcase
        return 32'(r % lim);
    endfunction

    // One operation on the 4-bit instance; inj >= 0 pulses start at that busy cycle.
    task automatic op4(input logic [2:0] f, input logic [3:0] a, input int inj);
        logic [7:0] exp, old;
        exp = 8'(ref_op(int'(f), longint'(a), longint'(m_res4[3:0]), 4));
        old = m_res4;
        fun4 = f; a4 = a; start4 = 1'b1;
        step();
        start4 = 1'b0;
        if (f == FUN_MUL) begin
            for (int i = 0; i < 4; i++) begin
                chk("mul4 busy", busy4, 1);
                chk("mul4 hold", result4, old);
                chk("mul4 done early", done4, 0);
                if (i == 0) chk("mul4 state", st4, ST_MUL);
                a4 = 4'($urandom);
                fun4 = 3'($urandom);
                start4 = (i == inj);
                if (i == inj) fun4 = 3'(FUN_ADD_RC);
                step();
            end
            start4 = 1'b0;
        end
        chk("op4 result", result4, exp);
        chk("op4 done", done4, 1);
        chk("op4 busy", busy4, 0);
        m_res4 = exp;
        step();
        chk("op4 done pulse", done4, 0);
    endtask

    // One operation on the 8-bit instance.
    task automatic op8(input logic [2:0] f, input logic [7:0] a);
        logic [15:0] exp, old;
        exp = 16'(ref_op(int'(f), longint'(a), longint'(m_res8[7:0]), 8));
        old = m_res8;
        fun8 = f; a8 = a; start8 = 1'b1;
        step();
        start8 = 1'b0;
        if (f == FUN_MUL) begin
            for (int i = 0; i < 8; i++) begin
                chk("mul8 busy", busy8, 1);
                chk("mul8 hold", result8, old);
                a8 = 8'($urandom);
                fun8 = 3'($urandom);
                step();
            end
        end
        chk("op8 result", result8, exp);
        chk("op8 done", done8, 1);
        chk("op8 busy", busy8, 0);
        m_res8 = exp;
        step();
        chk("op8 done pulse", done8, 0);
    endtask

    int seen;

    initial begin
        rst4_n = 1'b0; start4 = 1'b1; a4 = 4'h5; fun4 = 3'(FUN_ADD_RC);
        rst8_n = 1'b0; start8 = 1'b0; a8 = 8'h0; fun8 = 3'(FUN_INC);
        m_res4 = '0; m_res8 = '0;

        // Test 1: reset overrides start
        step();
        chk("t1 reset result", result4, 8'h00);
        chk("t1 reset busy", busy4, 0);
        chk("t1 reset done", done4, 0);
        chk("t1 reset state", st4, ST_IDLE);
        rst4_n = 1'b1; start4 = 1'b0;
        step();
        chk("t1 idle done", done4, 0);

        // Test 2: accumulate
        op4(3'b001, 4'h3, -1); chk("t2 a=3", result4, 8'h03);
        op4(3'b001, 4'h5, -1); chk("t2 a=5", result4, 8'h08);
        op4(3'b000, 4'hF, -1); chk("t2 inc", result4, 8'h10);

        // Test 3: 0xF * 0xF
        rst4_n = 1'b0; step(); rst4_n = 1'b1; m_res4 = '0;
        op4(3'b010, 4'hF, -1); chk("t3 preload", result4, 8'h0F);
        op4(3'b111, 4'hF, -1); chk("t3 product", result4, 8'hE1);

        // Test 4: start during multiply is ignored
        rst4_n = 1'b0; step(); rst4_n = 1'b1; m_res4 = '0;
        op4(3'b010, 4'hF, -1);
        op4(3'b111, 4'hF, 1); chk("t4 product", result4, 8'hE1);

        // Test 5: reset aborts a multiply with no done afterwards
        fun4 = 3'b111; a4 = 4'h3; start4 = 1'b1;
        step();
        start4 = 1'b0;
        chk("t5 busy", busy4, 1);
        step();
        rst4_n = 1'b0;
        step();
        chk("t5 abort result", result4, 8'h00);
        chk("t5 abort busy", busy4, 0);
        chk("t5 abort done", done4, 0);
        rst4_n = 1'b1; m_res4 = '0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done4 || busy4) seen++;
        end
        chk("t5 no done after abort", seen, 0);
        op4(3'b001, 4'h1, -1); chk("t5 restart", result4, 8'h01);

        // Test 6: shifts and OR-reduce
        op4(3'b101, 4'h3, -1); chk("t6 shl 3", result4, 8'h08);
        op4(3'b101, 4'h9, -1); chk("t6 shl 9", result4, 8'h00);
        op4(3'b010, 4'h8, -1); chk("t6 load 8", result4, 8'h08);
        op4(3'b110, 4'h2, -1); chk("t6 shr 2", result4, 8'h02);
        op4(3'b110, 4'h4, -1); chk("t6 shr 4", result4, 8'h00);
        op4(3'b100, 4'h0, -1); chk("t6 or 0", result4, 8'h00);
        op4(3'b100, 4'h2, -1); chk("t6 or 2", result4, 8'h01);
        op4(3'b011, 4'hC, -1); chk("t6 logic", result4, 8'hDD);

        // start held high: one op per edge, feedback from the previous result
        fun4 = 3'b001; a4 = 4'h1; start4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic [7:0] e;
            e = 8'(ref_op(1, 1, longint'(m_res4[3:0]), 4));
            step();
            chk("held result", result4, e);
            chk("held done", done4, 1);
            m_res4 = e;
        end
        start4 = 1'b0;
        step();
        chk("held done drop", done4, 0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            op4(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), -1);
        end

        // WIDTH=8: tests 2 and 3
        rst8_n = 1'b1;
        step();
        chk("w8 reset result", result8, 16'h0000);
        op8(3'b001, 8'h03); chk("w8 a=3", result8, 16'h0003);
        op8(3'b001, 8'h05); chk("w8 a=5", result8, 16'h0008);
        op8(3'b000, 8'hFF); chk("w8 inc", result8, 16'h0100);
        rst8_n = 1'b0; step(); rst8_n = 1'b1; m_res8 = '0;
        op8(3'b010, 8'hFF); chk("w8 preload", result8, 16'h00FF);
        op8(3'b111, 8'hFF); chk("w8 product", result8, 16'hFE01);
        for (int i = 0; i < 15; i++) begin
            op8(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
